ifetch_unit: RTL and testbench

- Instruction-fetch requester for the core's synchronous instruction memory (memory port: address sampled on clk; word available the following cycle, indexed by address bits [14:2]).
- Generates sequential word addresses and pairs each returned word with its PC.
- Buffers returned words in a 2-entry skid buffer and delivers them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) that flush all in-flight and buffered fetches.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_skid_buf.sv | 53 +++++
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch constants and the fetch-entry bundle.
// IFETCH_FAULT_EN adds a per-entry fault flag.
package ifetch_pkg;

   localparam int          INSN_W       = 32;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INSN_W-1:0] insn;
`ifdef IFETCH_FAULT_EN
      logic              fault;
`endif
   } fetch_ent_t;

endpackage

// File: rtl/ifetch_skid_buf.sv
// Two-entry {pc, insn[, fault]} FIFO with push/pop/flush.
// Head entry is kept when the buffer drains so outputs hold.
module ifetch_skid_buf
   import ifetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  fetch_ent_t din,
   output fetch_ent_t head,
   output logic [1:0] count
);

   fetch_ent_t e0, e1;
   logic [1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) e0 <= din;
               else             e1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               if (cnt == 2'd2) e0 <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd2) begin
                  e0 <= e1;
                  e1 <= din;
               end else begin
                  e0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = e0;
   assign count = cnt;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: sequential issue, response tracking, skid buffer.
// IFETCH_FAULT_EN adds out_fault (out-of-range / misaligned redirect).
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int          IMEM_ADDR_W = 15
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_insn
`ifdef IFETCH_FAULT_EN
   ,
   output logic        out_fault
`endif
);

   localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

   logic [31:0] issue_pc;
   logic [31:0] inflight_pc;
   logic        inflight_valid;
   logic [1:0]  count;
   logic [2:0]  occ;
   logic        pop, push, issue_en;
   fetch_ent_t  din, head;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;
   // Slots already claimed once this cycle's pop retires
   assign occ       = {1'b0, count} + {2'b0, inflight_valid}
                    - {2'b0, pop};
   assign issue_en  = !redirect_valid && (occ < 3'd2);
   assign push      = inflight_valid & ~redirect_valid;
   assign imem_addr = issue_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_pc       <= PC0;
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
      end else if (redirect_valid) begin
         issue_pc       <= {redirect_pc[31:2], 2'b00};
         inflight_valid <= 1'b0;
      end else if (issue_en) begin
         inflight_valid <= 1'b1;
         inflight_pc    <= issue_pc;
         issue_pc       <= issue_pc + PC_INC;
      end else begin
         inflight_valid <= 1'b0;
      end
   end

`ifdef IFETCH_FAULT_EN
   logic mis_pending, inflight_mis;

   // Misalignment belongs only to the first fetch after the redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_pending  <= 1'b0;
         inflight_mis <= 1'b0;
      end else if (redirect_valid) begin
         mis_pending  <= |redirect_pc[1:0];
         inflight_mis <= 1'b0;
      end else if (issue_en) begin
         inflight_mis <= mis_pending;
         mis_pending  <= 1'b0;
      end else begin
         inflight_mis <= 1'b0;
      end
   end
`else
   logic unused_bits;
   assign unused_bits = (^redirect_pc[1:0]) ^ (IMEM_ADDR_W == 0);
`endif

   always_comb begin
      din      = '0;
      din.pc   = inflight_pc;
      din.insn = imem_rd_data;
`ifdef IFETCH_FAULT_EN
      din.fault = inflight_mis | (|inflight_pc[31:IMEM_ADDR_W]);
`endif
   end

   ifetch_skid_buf u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign out_pc   = head.pc;
   assign out_insn = head.insn;
`ifdef IFETCH_FAULT_EN
   assign out_fault = head.fault;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed vector bench for ifetch_unit with a synchronous memory model.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
`ifdef IFETCH_FAULT_EN
   logic        out_fault;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Word i holds 0x1000_0000 + i, indexed by address bits [14:2]
   always @(posedge clk)
      imem_rd_data <= 32'h1000_0000 + {19'd0, imem_addr[14:2]};

   ifetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rd_data   (imem_rd_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_insn       (out_insn)
`ifdef IFETCH_FAULT_EN
      ,
      .out_fault      (out_fault)
`endif
   );

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einsn;
      logic [31:0] eaddr;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy,
                               logic ev, logic [31:0] epc,
                               logic [31:0] einsn, logic [31:0] eaddr);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
      v.epc = epc; v.einsn = einsn; v.eaddr = eaddr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic rv, input logic [31:0] rpc,
                       input logic rdy);
      @(posedge clk);
      #1;
      rst = 1'b0;
      redirect_valid = rv;
      redirect_pc = rpc;
      out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic apply(input int i);
      step(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid},
          {31'd0, tbl[i].ev});
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
         chk($sformatf("v%0d_pc", i), out_pc, tbl[i].epc);
         chk($sformatf("v%0d_insn", i), out_insn, tbl[i].einsn);
      end
   endtask

   initial begin
      //            rv   rpc           rdy  ev   epc           einsn         eaddr
      tbl[0]  = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0);
      tbl[1]  = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h4);
      tbl[2]  = mk(0, 32'h0,        1, 1, 32'h0,        32'h1000_0000, 32'h8);
      tbl[3]  = mk(0, 32'h0,        1, 1, 32'h4,        32'h1000_0001, 32'hC);
      tbl[4]  = mk(0, 32'h0,        0, 1, 32'h8,        32'h1000_0002, 32'h10);
      tbl[5]  = mk(0, 32'h0,        0, 1, 32'h8,        32'h1000_0002, 32'h10);
      tbl[6]  = mk(0, 32'h0,        0, 1, 32'h8,        32'h1000_0002, 32'h10);
      tbl[7]  = mk(0, 32'h0,        0, 1, 32'h8,        32'h1000_0002, 32'h10);
      tbl[8]  = mk(0, 32'h0,        0, 1, 32'h8,        32'h1000_0002, 32'h10);
      tbl[9]  = mk(0, 32'h0,        1, 1, 32'h8,        32'h1000_0002, 32'h10);
      tbl[10] = mk(0, 32'h0,        1, 1, 32'hC,        32'h1000_0003, 32'h14);
      tbl[11] = mk(0, 32'h0,        1, 1, 32'h10,       32'h1000_0004, 32'h18);
      tbl[12] = mk(0, 32'h0,        0, 1, 32'h14,       32'h1000_0005, 32'h1C);
      tbl[13] = mk(1, 32'h102,      0, 1, 32'h14,       32'h1000_0005, 32'h1C);
      tbl[14] = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h100);
      tbl[15] = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h104);
      tbl[16] = mk(0, 32'h0,        1, 1, 32'h100,      32'h1000_0040, 32'h108);
      tbl[17] = mk(1, 32'hFFFF_FFFC, 1, 1, 32'h104,     32'h1000_0041, 32'h10C);
      tbl[18] = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'hFFFF_FFFC);
      tbl[19] = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0);
      tbl[20] = mk(0, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'h1000_1FFF, 32'h4);
      tbl[21] = mk(0, 32'h0,        1, 1, 32'h0,        32'h1000_0000, 32'h8);
      tbl[22] = mk(1, 32'h200,      1, 1, 32'h4,        32'h1000_0001, 32'hC);
      tbl[23] = mk(1, 32'h300,      1, 0, 32'h0,        32'h0,        32'h200);
      tbl[24] = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h300);
      tbl[25] = mk(0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h304);
      tbl[26] = mk(0, 32'h0,        1, 1, 32'h300,      32'h1000_00C0, 32'h308);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_insn", out_insn, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);

      for (int i = 0; i < NV; i++) apply(i);

      // Asynchronous reset between clock edges
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'h0);
      chk("async_rst_addr", imem_addr, 32'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) apply(i);

`ifdef IFETCH_FAULT_EN
      step(1, 32'h0000_8000, 1);
      step(0, 32'h0, 1);
      step(0, 32'h0, 1);
      step(0, 32'h0, 1);
      chk("rng_valid", {31'd0, out_valid}, 32'h1);
      chk("rng_pc", out_pc, 32'h8000);
      chk("rng_fault", {31'd0, out_fault}, 32'h1);
      step(1, 32'h0000_0006, 1);
      step(0, 32'h0, 1);
      step(0, 32'h0, 1);
      step(0, 32'h0, 1);
      chk("mis_pc", out_pc, 32'h4);
      chk("mis_fault", {31'd0, out_fault}, 32'h1);
      step(0, 32'h0, 1);
      chk("mis_next_pc", out_pc, 32'h8);
      chk("mis_next_fault", {31'd0, out_fault}, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
